pipelined_adder: RTL and testbench
==================================

# pipelined_adder

Parametrised, pipelined ripple-carry adder that splits a WIDTH-bit addition into STAGES equal chunks, one chunk per register stage, with the carry passed stage to stage. Successor to the single-bit full adder: arbitrary width, valid/ready flow control, carry-out and signed-overflow flags, and an optional subtract mode. Sits between any valid/ready producer and consumer in the datapath and sustains one operation per cycle.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of STAGES
- STAGES, 4, pipeline depth; chunk width CW = WIDTH/STAGES; STAGES >= 1
- CLK  input  1  clock; all state updates on rising edge
- RST  input  1  synchronous, active-high reset
- IN_VALID  input  1  operand beat present
- IN_READY  output  1  block accepts beat this cycle
- A  input  WIDTH  operand A
- B  input  WIDTH  operand B
- Cin  input  1  carry into bit 0
- SUB  input  1  subtract select; present only when ADD_SUB_EN defined
- OUT_VALID  output  1  result beat present
- OUT_READY  input  1  consumer accepts result
- SUM  output  WIDTH  result
- Cout  output  1  carry out of bit WIDTH-1
- OVF  output  1  two's-complement overflow

## Operation
- Transfer on a port occurs when VALID and READY are both 1 on a rising edge.
- Stage k (0..STAGES-1) adds bits [k*CW +: CW] of A and B plus the carry from stage k-1 (stage 0 uses Cin); registers the CW-bit partial sum, the carry out, the already-finished lower sum bits, and the not-yet-used upper A/B bits.
- Each stage holds a valid bit v[k]. Stage k loads when v[k]==0 or stage k+1 loads; last stage "loads next" when OUT_READY==1. Stage 0 loads a new beat only if IN_VALID.
- IN_READY = stage-0 load condition (combinational from OUT_READY through the chain); forced 0 while RST high.
- Bubbles collapse: an empty stage accepts from upstream even when downstream is stalled.
- Outputs SUM/Cout/OVF/OUT_VALID are driven directly from last-stage registers.
- Cout = carry out of the MSB chunk. OVF = carry into MSB XOR carry out of MSB.
- Results leave in acceptance order; no beat dropped or duplicated.
- Arithmetic is modulo 2^WIDTH; SUM has no extra bit.

## Timing
- Latency: beat accepted at edge t produces OUT_VALID=1 after edge t+STAGES-1 (visible in cycle following edge t+STAGES-1) when unstalled; STAGES=1 gives one cycle.
- Throughput: one beat per cycle with OUT_READY held 1.
- Stall: while OUT_VALID=1 and OUT_READY=0, SUM/Cout/OVF hold stable; upstream stages fill; IN_READY falls to 0 once all STAGES stages valid.
- Simultaneous: full pipeline with OUT_READY=1 and IN_VALID=1 accepts and retires in the same cycle.
- Reset: on edge with RST=1 all v[k]=0, OUT_VALID=0, SUM=0, Cout=0, OVF=0; in-flight beats discarded; IN_READY=0 during RST, 1 in the first cycle after RST deasserts.
- RST mid-operation dominates any handshake in that cycle; transfer on that edge does not occur.

## Configuration
- ADD_SUB_EN defined: SUB port exists; at stage 0 a beat with SUB=1 captures B inverted and forces carry-in to 1 (Cin ignored); SUB travels with the beat. Cout=1 means no borrow; OVF uses the same rule.
- ADD_SUB_EN undefined: no SUB port; block adds only, Cin used as given.

## Test plan
- WIDTH=16, STAGES=4, single beat A=16'hFFFF B=16'h0001 Cin=0 -> SUM=16'h0000 Cout=1 OVF=0, OUT_VALID exactly 4 cycles after acceptance.
- 8 back-to-back beats A=i, B=16'h0100*i, Cin=i[0] -> 8 results in order, one per cycle, no gaps, each SUM = A+B+Cin.
- Continuous IN_VALID, OUT_READY=0 for 10 cycles -> exactly 4 beats accepted, IN_READY=0 thereafter, SUM held stable; on release all beats drain in order, none lost or repeated.
- A=16'h7FFF B=16'h0001 Cin=0 -> SUM=16'h8000 OVF=1 Cout=0; A=16'h8000 B=16'h8000 -> SUM=0 OVF=1 Cout=1.
- RST pulsed with 3 beats in flight -> OUT_VALID=0 and SUM=0 after that edge, no stale beat ever appears; IN_READY=1 cycle after RST drops.
- ADD_SUB_EN: SUB=1 A=16'h0005 B=16'h0007 -> SUM=16'hFFFE Cout=0 OVF=0; SUB=1 A=16'h8000 B=16'h0001 -> SUM=16'h7FFF OVF=1 Cout=1.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined ripple-carry adder, one CW-bit chunk per stage, valid/ready flow.
// Define ADD_SUB_EN to add the SUB port (A - B via inverted B, carry-in 1).
module pipelined_adder #(
  parameter int WIDTH  = 16,
  parameter int STAGES = 4
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             IN_VALID,
  output logic             IN_READY,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
`ifdef ADD_SUB_EN
  input  logic             SUB,
`endif
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout,
  output logic             OVF
);

  localparam int CW = WIDTH / STAGES;

  logic [STAGES:0]   ld;
  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] c_q;
  logic [STAGES-1:0] o_q;
  logic [WIDTH-1:0]  a_q [STAGES];
  logic [WIDTH-1:0]  b_q [STAGES];
  logic [WIDTH-1:0]  s_q [STAGES];

  assign ld[STAGES] = OUT_READY;
  assign IN_READY   = ld[0] & ~RST;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    logic             vi;
    logic             ci;
    logic [WIDTH-1:0] ai;
    logic [WIDTH-1:0] bi;
    logic [WIDTH-1:0] si;
    logic [WIDTH-1:0] sn;
    logic [CW:0]      ch;
    logic             ovf_n;

    if (k == 0) begin : g_src
      assign vi = IN_VALID;
      assign ai = A;
      assign si = '0;
`ifdef ADD_SUB_EN
      assign bi = SUB ? ~B : B;
      assign ci = SUB ? 1'b1 : Cin;
`else
      assign bi = B;
      assign ci = Cin;
`endif
    end else begin : g_src
      assign vi = v_q[k-1];
      assign ai = a_q[k-1];
      assign bi = b_q[k-1];
      assign si = s_q[k-1];
      assign ci = c_q[k-1];
    end

    assign ch = {1'b0, ai[k*CW +: CW]}
              + {1'b0, bi[k*CW +: CW]}
              + {{CW{1'b0}}, ci};

    always_comb begin
      sn = si;
      sn[k*CW +: CW] = ch[CW-1:0];
    end

    // carry into the chunk MSB recovered as a^b^s at that bit
    assign ovf_n = ai[k*CW+CW-1] ^ bi[k*CW+CW-1]
                 ^ ch[CW-1] ^ ch[CW];

    assign ld[k] = ~v_q[k] | ld[k+1];

    always_ff @(posedge CLK) begin
      if (RST) begin
        v_q[k] <= 1'b0;
        c_q[k] <= 1'b0;
        o_q[k] <= 1'b0;
        a_q[k] <= '0;
        b_q[k] <= '0;
        s_q[k] <= '0;
      end else if (ld[k]) begin
        v_q[k] <= vi;
        if (vi) begin
          c_q[k] <= ch[CW];
          o_q[k] <= ovf_n;
          a_q[k] <= ai;
          b_q[k] <= bi;
          s_q[k] <= sn;
        end
      end
    end
  end

  assign OUT_VALID = v_q[STAGES-1];
  assign SUM       = s_q[STAGES-1];
  assign Cout      = c_q[STAGES-1];
  assign OVF       = o_q[STAGES-1];

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=16, STAGES=4).
// Output beats are also scored in order against a reference queue.
module tb_pipelined_adder;

  logic        CLK = 1'b0;
  logic        RST = 1'b1;
  logic        IN_VALID = 1'b0;
  logic        IN_READY;
  logic [15:0] A = '0;
  logic [15:0] B = '0;
  logic        Cin = 1'b0;
  logic        OUT_VALID;
  logic        OUT_READY = 1'b1;
  logic [15:0] SUM;
  logic        Cout;
  logic        OVF;
  logic        sub_w;
`ifdef ADD_SUB_EN
  logic        SUB = 1'b0;
  assign sub_w = SUB;
`else
  assign sub_w = 1'b0;
`endif

  int checks   = 0;
  int failures = 0;
  int nout     = 0;

  typedef struct packed {
    logic [15:0] s;
    logic        c;
    logic        o;
  } res_t;

  res_t q[$];

  always #5 CLK = ~CLK;

  pipelined_adder #(.WIDTH(16), .STAGES(4)) dut (
    .CLK(CLK),
    .RST(RST),
    .IN_VALID(IN_VALID),
    .IN_READY(IN_READY),
    .A(A),
    .B(B),
    .Cin(Cin),
`ifdef ADD_SUB_EN
    .SUB(SUB),
`endif
    .OUT_VALID(OUT_VALID),
    .OUT_READY(OUT_READY),
    .SUM(SUM),
    .Cout(Cout),
    .OVF(OVF)
  );

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic res_t model(input logic [15:0] a,
                                 input logic [15:0] b,
                                 input logic ci,
                                 input logic sub);
    logic [15:0] bb;
    logic        c0;
    logic [16:0] r;
    res_t        x;
    bb  = sub ? ~b : b;
    c0  = sub ? 1'b1 : ci;
    r   = {1'b0, a} + {1'b0, bb} + {16'b0, c0};
    x.s = r[15:0];
    x.c = r[16];
    x.o = (a[15] == bb[15]) && (r[15] != a[15]);
    return x;
  endfunction

  always @(negedge CLK) begin : mon
    res_t e;
    if (RST) begin
      q.delete();
    end else begin
      if (OUT_VALID && OUT_READY) begin
        if (q.size() == 0) begin
          check("spurious_out", 1, 0);
        end else begin
          e = q.pop_front();
          check("sb_sum", SUM, e.s);
          check("sb_cout", Cout, e.c);
          check("sb_ovf", OVF, e.o);
        end
        nout++;
      end
      if (IN_VALID && IN_READY)
        q.push_back(model(A, B, Cin, sub_w));
    end
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic single(input string tag,
                        input logic [15:0] a,
                        input logic [15:0] b,
                        input logic ci,
                        input logic sub,
                        input logic [15:0] es,
                        input logic ec,
                        input logic eo);
    int n;
    A   = a;
    B   = b;
    Cin = ci;
`ifdef ADD_SUB_EN
    SUB = sub;
`endif
    IN_VALID = 1'b1;
    check({tag, "_rdy"}, IN_READY, 1);
    step();
    IN_VALID = 1'b0;
    n = 1;
    while (!OUT_VALID && n < 20) begin
      step();
      n++;
    end
    check({tag, "_lat"}, n, 4);
    check({tag, "_sum"}, SUM, es);
    check({tag, "_cout"}, Cout, ec);
    check({tag, "_ovf"}, OVF, eo);
    step();
`ifdef ADD_SUB_EN
    SUB = 1'b0;
`endif
  endtask

  initial begin
    logic [13:0] hist;
    logic [15:0] held;
    logic        seen;
    logic        stale;
    int          acc;
    int          n0;

    RST = 1'b1;
    step();
    step();
    check("rst_valid", OUT_VALID, 0);
    check("rst_sum", SUM, 0);
    check("rst_cout", Cout, 0);
    check("rst_ovf", OVF, 0);
    check("rst_ready", IN_READY, 0);
    RST = 1'b0;
    #1;
    check("ready_post_rst", IN_READY, 1);

    single("wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);

    hist = '0;
    for (int i = 0; i < 14; i++) begin
      if (i < 8) begin
        A        = 16'(i);
        B        = 16'(i) << 8;
        Cin      = i[0];
        IN_VALID = 1'b1;
        check("b2b_rdy", IN_READY, 1);
      end else begin
        IN_VALID = 1'b0;
      end
      step();
      hist[i] = OUT_VALID;
      if (i == 10)
        check("b2b_last", SUM, 16'h0708);
    end
    check("b2b_hist", hist, 14'h07F8);

    OUT_READY = 1'b0;
    acc  = 0;
    seen = 1'b0;
    held = '0;
    for (int i = 0; i < 10; i++) begin
      A        = 16'h1000 + 16'(i);
      B        = 16'h0200;
      Cin      = 1'b0;
      IN_VALID = 1'b1;
      if (IN_READY)
        acc++;
      step();
      if (OUT_VALID && !seen) begin
        seen = 1'b1;
        held = SUM;
      end
    end
    check("stall_acc", acc, 4);
    check("stall_rdy", IN_READY, 0);
    check("stall_seen", seen, 1);
    check("stall_first", held, 16'h1200);
    check("stall_hold", SUM, held);
    IN_VALID  = 1'b0;
    OUT_READY = 1'b1;
    n0 = nout;
    repeat (8) step();
    check("stall_drain", nout - n0, 4);

    single("ovf_pos", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    single("ovf_neg", 16'h8000, 16'h8000, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b1);

    for (int i = 0; i < 3; i++) begin
      A        = 16'h00A0 + 16'(i);
      B        = 16'h0001;
      Cin      = 1'b0;
      IN_VALID = 1'b1;
      step();
    end
    IN_VALID = 1'b0;
    RST      = 1'b1;
    step();
    check("mid_rst_valid", OUT_VALID, 0);
    check("mid_rst_sum", SUM, 0);
    check("mid_rst_ready", IN_READY, 0);
    RST = 1'b0;
    #1;
    check("mid_rst_ready1", IN_READY, 1);
    n0    = nout;
    stale = 1'b0;
    repeat (8) begin
      step();
      if (OUT_VALID)
        stale = 1'b1;
    end
    check("no_stale", stale, 0);
    check("no_stale_n", nout - n0, 0);

`ifdef ADD_SUB_EN
    single("sub_small", 16'h0005, 16'h0007, 1'b0, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    single("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
`endif

    check("sb_empty", q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
